dac_grad_spi_rx: RTL

- SPI slave endpoint that pairs with the gradient-DAC SPI master.
- Fixed framing: mode CPOL=1/CPHA=0, MSB first, 24-bit frames, one frame per SS_n assertion.
- Oversamples SCLK/SS_n/MOSI in the 50 MHz clk domain. Delivers each complete received word on a valid/ready port and shifts a readback word out on MISO.
- Used as the on-board DAC-side decoder and as a loopback checker for the gradient SPI path.

---
 rtl/dac_grad_spi_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dac_grad_spi_rx.sv
// dac_grad_spi_rx
// SPI slave endpoint for the gradient-DAC SPI link (CPOL=1, CPHA=0, MSB first,
// one DATABITS-bit frame per SS_n assertion). The SPI pins are oversampled in
// the clk domain. Each complete word is delivered on a valid/ready port, and a
// readback word is shifted out on MISO at the same time.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   SCLK, SS_n, MOSI    asynchronous SPI inputs (SCLK idles high)
//   MISO                serial readback to the master, idles high, always driven
//   tx_data             readback word, captured when SS_n falls
//   rx_data / rx_valid  last complete word and its "unconsumed" flag
//   rx_ready            consumer accept (rx_valid & rx_ready pops the word)
//   rx_overrun          sticky: a new word replaced one that was not consumed
//   frame_error         sticky: a frame ended with the wrong bit count
//   status_clear        pulse that clears both sticky flags
module dac_grad_spi_rx #(
    parameter int DATABITS    = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCLK,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [DATABITS-1:0] tx_data,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_overrun,
    output logic                frame_error,
    input  logic                status_clear
);

    localparam int CNT_W   = $clog2(DATABITS + 2);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 3);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DATABITS);
    localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(DATABITS + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                  sclk_dly_q, sclk_dly_d, ss_dly_q, ss_dly_d;
    logic                  sclk_fall_q, sclk_fall_d, sclk_rise_q, sclk_rise_d;
    logic                  ss_fall_q, ss_fall_d, ss_rise_q, ss_rise_d;
    logic                  mosi_smp_q, mosi_smp_d;
    logic [FLUSH_W-1:0]    flush_q, flush_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATABITS-1:0]   rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [DATABITS-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d, ferr_q, ferr_d;
    logic                  miso_q, miso_d;
    logic                  commit, ferr_set;

    // Synchronizers, delayed copies and registered edge pulses. The edge pulses
    // and the sampled MOSI bit come out of the same register stage, so a
    // falling-edge pulse always pairs with the MOSI value present at that edge.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        ss_dly_d    = ss_sync_q[SYNC_STAGES-1];
        sclk_fall_d = sclk_dly_q & ~sclk_sync_q[SYNC_STAGES-1];
        sclk_rise_d = ~sclk_dly_q & sclk_sync_q[SYNC_STAGES-1];
        ss_fall_d   = ss_dly_q & ~ss_sync_q[SYNC_STAGES-1];
        ss_rise_d   = ~ss_dly_q & ss_sync_q[SYNC_STAGES-1];
        mosi_smp_d  = mosi_sync_q[SYNC_STAGES-1];
    end

    // Frame FSM, output handshake and sticky flags.
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        commit     = 1'b0;
        ferr_set   = 1'b0;

        unique case (state_q)
            // The sync chain resets to all ones. If SS_n is really low at that
            // point, the chain shows a false high for SYNC_STAGES cycles. So
            // SS_n must be seen high for longer than that before frames are
            // accepted.
            WAIT_IDLE: begin
                if (ss_sync_q[SYNC_STAGES-1]) begin
                    if (flush_q == FLUSH_END) begin
                        state_d = IDLE;
                        flush_d = '0;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end else begin
                    flush_d = '0;
                end
            end
            IDLE: begin
                if (ss_fall_q) begin
                    tx_sh_d   = {tx_data[DATABITS-2:0], 1'b0};
                    miso_d    = tx_data[DATABITS-1];
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                // The end of the frame takes priority over an SCLK edge in the same cycle.
                if (ss_rise_q) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        commit = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    miso_d  = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall_q) begin
                    rx_sh_d = {rx_sh_q[DATABITS-2:0], mosi_smp_q};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_rise_q) begin
                    if (bit_cnt_q < CNT_FULL) begin
                        miso_d  = tx_sh_q[DATABITS-1];
                        tx_sh_d = {tx_sh_q[DATABITS-2:0], 1'b0};
                    end else begin
                        miso_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        rx_valid_d = rx_valid_q & ~rx_ready;
        if (commit) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
        end

        // A set event in the same cycle as status_clear takes priority.
        overrun_d = status_clear ? 1'b0 : overrun_q;
        if (commit && rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
        end
        ferr_d = status_clear ? 1'b0 : ferr_q;
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            sclk_sync_q <= '1;
            ss_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_dly_q  <= 1'b1;
            ss_dly_q    <= 1'b1;
            sclk_fall_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            mosi_smp_q  <= 1'b1;
            flush_q     <= '0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            sclk_fall_q <= sclk_fall_d;
            sclk_rise_q <= sclk_rise_d;
            ss_fall_q   <= ss_fall_d;
            ss_rise_q   <= ss_rise_d;
            mosi_smp_q  <= mosi_smp_d;
            flush_q     <= flush_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = overrun_q;
    assign frame_error = ferr_q;

endmodule
